mbox_cyc_arb: RTL

//  Arbitrates MBOX cache/memory cycles among four requesters: MB writeback, CCA
//  (cache clearer), channel and EBOX. Samples requests when idle and issues one

---
 rtl/mbox_cyc_arb.sv | 136 +++++++++++++
 1 files changed

// File: rtl/mbox_cyc_arb.sv
// MBOX cycle arbiter: one registered one-hot grant among MB, CCA, CHAN and EBOX,
// held until CSH reports cycle done or a timeout fires. Optional EBOX anti-starvation: MBOX_ARB_FAIRNESS_EN.
module mbox_cyc_arb #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned TW             = 7,
  parameter int unsigned STARVE_LIMIT   = 8
) (
  input  logic       clk,
  input  logic       CROBAR,
  input  logic       mbReq,
  input  logic       ccaReq,
  input  logic       chanReq,
  input  logic       eboxReq,
  input  logic       eboxRetry,
  input  logic       pageFailHold,
  input  logic       cycDone,
  input  logic       errClr,
  output logic [3:0] grant,
  output logic       cycActive,
  output logic       t0,
  output logic       sbusErr
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [3:0]    G_MB     = 4'b1000;
  localparam logic [3:0]    G_CCA    = 4'b0100;
  localparam logic [3:0]    G_CHAN   = 4'b0010;
  localparam logic [3:0]    G_EBOX   = 4'b0001;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_MAX  = '1;

  if (TIMEOUT_CYCLES < 2 || (64'd1 << TW) < 64'(TIMEOUT_CYCLES) || STARVE_LIMIT == 0) begin : g_param_err
    $error("mbox_cyc_arb: illegal parameter combination");
  end

  state_t          state_q, state_d;
  logic [3:0]      grant_d;
  logic            cyc_active_d, t0_d, sbus_err_d;
  logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic            ebox_elig_c, boost_c;
  logic [3:0]      winner_c;

  assign ebox_elig_c = eboxReq & ~pageFailHold;

`ifdef MBOX_ARB_FAIRNESS_EN
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_cnt_q, starve_cnt_d;

  assign boost_c = ebox_elig_c && (starve_cnt_q == SW'(STARVE_LIMIT));

  // Counts consecutive arbitrations EBOX lost while eligible; saturates at the limit.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (state_q == IDLE) begin
      if (!ebox_elig_c || winner_c == G_EBOX) begin
        starve_cnt_d = '0;
      end else if (winner_c != 4'b0000 && starve_cnt_q != SW'(STARVE_LIMIT)) begin
        starve_cnt_d = starve_cnt_q + SW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (CROBAR) starve_cnt_q <= '0;
    else        starve_cnt_q <= starve_cnt_d;
  end
`else
  assign boost_c = 1'b0;
`endif

  // Fixed priority; a pending EBOX retry jumps ahead of CHAN only.
  always_comb begin
    winner_c = 4'b0000;
    if (boost_c)                        winner_c = G_EBOX;
    else if (mbReq)                     winner_c = G_MB;
    else if (ccaReq)                    winner_c = G_CCA;
    else if (ebox_elig_c && eboxRetry)  winner_c = G_EBOX;
    else if (chanReq)                   winner_c = G_CHAN;
    else if (ebox_elig_c)               winner_c = G_EBOX;
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant;
    cyc_active_d = cycActive;
    t0_d         = 1'b0;
    sbus_err_d   = sbusErr & ~errClr;
    tmo_cnt_d    = tmo_cnt_q;
    case (state_q)
      IDLE: begin
        if (winner_c != 4'b0000) begin
          state_d      = BUSY;
          grant_d      = winner_c;
          cyc_active_d = 1'b1;
          t0_d         = 1'b1;
          tmo_cnt_d    = '0;
        end
      end
      BUSY: begin
        if (tmo_cnt_q != TMO_MAX) tmo_cnt_d = tmo_cnt_q + TW'(1);
        // cycDone on the terminal cycle wins over the timeout.
        if (cycDone) begin
          state_d      = IDLE;
          grant_d      = 4'b0000;
          cyc_active_d = 1'b0;
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d      = IDLE;
          grant_d      = 4'b0000;
          cyc_active_d = 1'b0;
          sbus_err_d   = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (CROBAR) begin
      state_q   <= IDLE;
      grant     <= 4'b0000;
      cycActive <= 1'b0;
      t0        <= 1'b0;
      sbusErr   <= 1'b0;
      tmo_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      grant     <= grant_d;
      cycActive <= cyc_active_d;
      t0        <= t0_d;
      sbusErr   <= sbus_err_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

endmodule
